// File: rtl/button_conditioner.sv
// button_conditioner
//   Multi-channel push-button conditioner: two-flop synchroniser, symmetric
//   press/release debounce and registered one-cycle press/release strobes.
//   Optional auto-repeat of press strobes while held, compiled in with
//   `BUTTON_CONDITIONER_REPEAT_EN.
//
// Ports
//   clk           in   1         system clock, rising edge
//   rst_n         in   1         synchronous active-low reset
//   btn           in   CHANNELS  raw asynchronous buttons, 1 = pressed
//   state         out  CHANNELS  debounced level
//   press         out  CHANNELS  one-cycle strobe on accepted press (and repeats)
//   release_pulse out  CHANNELS  one-cycle strobe on accepted release
//                                (`release` is a reserved word in SystemVerilog)
module button_conditioner #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);

    // Reject unusable parameterisations at elaboration.
    if (CHANNELS < 1 || STABLE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("button_conditioner: illegal parameter value");
    end

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } btn_state_e;

    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;
    btn_state_e          cur     [CHANNELS];
    btn_state_e          cur_n   [CHANNELS];
    logic [CNT_W-1:0]    cnt     [CHANNELS];
    logic [CNT_W-1:0]    cnt_n   [CHANNELS];
    logic [CHANNELS-1:0] press_n;
    logic [CHANNELS-1:0] rel_n;

`ifdef BUTTON_CONDITIONER_REPEAT_EN
    localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0]    rcnt   [CHANNELS];
    logic [RPT_W-1:0]    rcnt_n [CHANNELS];
    logic [CHANNELS-1:0] rep;      // first repeat already issued for this hold
    logic [CHANNELS-1:0] rep_n;
`endif

    // State register: synchroniser, debounce counters, level FSM, strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1            <= '0;
            s2            <= '0;
            press         <= '0;
            release_pulse <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cur[i] <= IDLE;
                cnt[i] <= '0;
`ifdef BUTTON_CONDITIONER_REPEAT_EN
                rcnt[i] <= '0;
`endif
            end
`ifdef BUTTON_CONDITIONER_REPEAT_EN
            rep <= '0;
`endif
        end else begin
            s1            <= btn;
            s2            <= s1;
            press         <= press_n;
            release_pulse <= rel_n;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cur[i] <= cur_n[i];
                cnt[i] <= cnt_n[i];
`ifdef BUTTON_CONDITIONER_REPEAT_EN
                rcnt[i] <= rcnt_n[i];
`endif
            end
`ifdef BUTTON_CONDITIONER_REPEAT_EN
            rep <= rep_n;
`endif
        end
    end

    // Next state: any agreeing sample clears the count; STABLE_CYCLES
    // consecutive disagreeing samples flip the level and fire a strobe.
    always_comb begin
        press_n = '0;
        rel_n   = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            cur_n[i] = cur[i];
            cnt_n[i] = cnt[i];
        end
`ifdef BUTTON_CONDITIONER_REPEAT_EN
        rep_n = rep;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            rcnt_n[i] = rcnt[i];
        end
`endif
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (s2[i] == (cur[i] == HELD)) begin
                cnt_n[i] = '0;
            end else if (cnt[i] == CNT_W'(STABLE_CYCLES - 1)) begin
                cnt_n[i]   = '0;
                cur_n[i]   = s2[i] ? HELD : IDLE;
                press_n[i] = s2[i];
                rel_n[i]   = ~s2[i];
            end else begin
                cnt_n[i] = cnt[i] + 1'b1;
            end
`ifdef BUTTON_CONDITIONER_REPEAT_EN
            // Idle, rising or releasing: restart the hold timer, no repeat.
            if (cur[i] == IDLE || cur_n[i] == IDLE) begin
                rcnt_n[i] = '0;
                rep_n[i]  = 1'b0;
            end else if (rcnt[i] == (rep[i] ? RPT_W'(REPEAT_CYCLES - 1) : RPT_W'(HOLD_CYCLES - 1))) begin
                rcnt_n[i]  = '0;
                rep_n[i]   = 1'b1;
                press_n[i] = 1'b1;
            end else begin
                rcnt_n[i] = rcnt[i] + 1'b1;
            end
`endif
        end
    end

    // Level output is the registered FSM state.
    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            state[i] = (cur[i] == HELD);
        end
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Multi-channel push-button conditioner for the stopwatch front panel: synchronises raw button inputs, debounces both press and release, and emits a per-channel level plus single-cycle press and release strobes. It sits between the board button pins and the stopwatch control FSM, replacing the single-channel, press-only debounce with a parametrised, symmetric one. An optional auto-repeat mode generates repeated press strobes while a button is held.

## Interface
Parameters:
- CHANNELS, 4, number of independent button channels (>= 1)
- STABLE_CYCLES, 1000000, consecutive differing samples needed to accept a new level (>= 2); 10 ms at 100 MHz
- HOLD_CYCLES, 50000000, cycles from accepted press to first repeat strobe (>= 1); used only with repeat compiled in
- REPEAT_CYCLES, 10000000, cycles between subsequent repeat strobes (>= 1); used only with repeat compiled in

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- btn  in  CHANNELS  raw asynchronous button inputs, 1 = pressed
- state  out  CHANNELS  debounced level per channel
- press  out  CHANNELS  one-cycle strobe on accepted press (and on repeats, if enabled)
- release  out  CHANNELS  one-cycle strobe on accepted release

## Operation
- Each channel is independent. Channels share only clk and rst_n.
- Synchroniser: two flops per channel, btn -> s1 -> s2, both reset to 0.
- Debounce counter cnt, width $clog2(STABLE_CYCLES), one per channel:
  - s2 == state: cnt <= 0.
  - s2 != state and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - s2 != state and cnt == STABLE_CYCLES-1: state <= s2, cnt <= 0.
- Any single sample with s2 == state clears cnt. A bounce restarts the count, and the count never wraps.
- Press and release are debounced symmetrically with the same STABLE_CYCLES.
- press[i] and release[i] are registered. Each is high for exactly the first cycle in which state[i] holds its new value, and low otherwise.
- Per-channel two-state view: IDLE (state=0) and HELD (state=1). IDLE->HELD asserts press. HELD->IDLE asserts release.
- Reset, with rst_n=0 at a clock edge: s1, s2, state, press, release, cnt and repeat counters all go to 0. Reset mid-count discards progress. A button held through reset is re-debounced from zero after reset deasserts.

## Timing
- Reset values: state=0, press=0, release=0 on every channel.
- Latency: btn steps and stays stable from before edge E. s2 holds the new value after edge E+1. state and the strobe change at edge E+1+STABLE_CYCLES, so the change is visible STABLE_CYCLES+2 cycles after btn changed.
- Minimum accepted pulse: btn must be stable for STABLE_CYCLES consecutive s2 samples. Shorter glitches produce no output.
- Strobe width: exactly 1 cycle. press and release never assert together on the same channel.
- Simultaneous events on different channels in the same cycle are each reported in their own bit, in the same cycle.

## Configuration
- Macro `BUTTON_CONDITIONER_REPEAT_EN`.
- Defined:
  - Each channel has a repeat counter, width $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1), cleared while state=0 and in the cycle state rises.
  - With the initial press at cycle T, repeat press strobes fire at T+HOLD_CYCLES, T+HOLD_CYCLES+REPEAT_CYCLES, T+HOLD_CYCLES+2·REPEAT_CYCLES, and so on, while state stays 1.
  - An accepted release stops repeats immediately. No repeat strobe can coincide with a release strobe.
- Undefined:
  - No repeat logic is synthesised. press fires only on IDLE->HELD.
  - HOLD_CYCLES and REPEAT_CYCLES are ignored.

## Test plan
Bench parameters: CHANNELS=2, STABLE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- Reset: hold rst_n=0 with btn=2'b11 for 5 cycles -> state, press and release are 0 throughout. After rst_n=1, state[1:0]=2'b11 and press=2'b11 for one cycle, 6 cycles later.
- Clean press/release: btn[0] 0->1, held 20 cycles -> state[0] rises 6 cycles after the step with a 1-cycle press[0]. btn[0] 1->0 -> state[0] falls 6 cycles later with a 1-cycle release[0].
- Bounce: btn[0] pattern 1,1,1,0,1,1,1,0 (each 1 cycle), then steady 1 -> no output during the bounce. state[0] rises 6 cycles after steady 1 begins.
- Glitch: btn[1] high for 3 cycles then low -> state[1], press[1] and release[1] remain 0.
- Independence: btn[0] and btn[1] rise in the same cycle -> press=2'b11 in the same single cycle. btn[0] released mid-hold -> release[0] only, with state[1] unaffected.
- Repeat, with the macro defined: press at cycle T, held 25 cycles -> press[0] at T, T+10, T+13, T+16, T+19, T+22, and no further strobes after the release is accepted. Without the macro, the same stimulus gives press[0] only at T.
